shift_exec_stage: RTL and testbench

Two-stage pipelined execute unit for all MIPS-style shift instructions. It sits between decode/issue and writeback, with valid/ready handshakes on both sides.
- Selects the operand and shift amount for immediate or variable forms.
- Pre-conditions the operand so left shifts can use the team's existing 32-bit logical right barrel shifter.
- Applies sign fill and registers the result with its destination tag.

---
 rtl/shift_pkg.sv | 55 +++++
 rtl/shift_exec_stage_bit_reverse32.sv | 15 +
 rtl/shift_exec_stage_shift_right32.sv | 18 +
 rtl/shift_exec_stage.sv | 136 +++++++++++++
 tb/tb_shift_exec_stage.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared constants, opcode decode and pipeline bundles
// for the shift execute stage.
package shift_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLLV = 3'b100;
  localparam logic [2:0] OP_SRLV = 3'b101;
  localparam logic [2:0] OP_SRAV = 3'b110;

  typedef struct packed {
    logic legal;
    logic is_left;
    logic is_arith;
    logic is_var;
  } op_dec_t;

  typedef struct packed {
    logic [XLEN-1:0] opnd;
    logic [4:0]      amt;
    logic            is_left;
    logic            fill_sign;
    logic            legal;
    logic [REGW-1:0] rd;
    logic            we;
  } s1_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [REGW-1:0] rd;
    logic            we;
  } s2_t;

  function automatic op_dec_t decode_op(
    input logic [2:0] op
  );
    op_dec_t d;
    d = '0;
    unique case (op)
      OP_SLL:  d = '{1'b1, 1'b1, 1'b0, 1'b0};
      OP_SRL:  d = '{1'b1, 1'b0, 1'b0, 1'b0};
      OP_SRA:  d = '{1'b1, 1'b0, 1'b1, 1'b0};
      OP_SLLV: d = '{1'b1, 1'b1, 1'b0, 1'b1};
      OP_SRLV: d = '{1'b1, 1'b0, 1'b0, 1'b1};
      OP_SRAV: d = '{1'b1, 1'b0, 1'b1, 1'b1};
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_exec_stage_bit_reverse32.sv
// Pure wiring: bit i of the output is bit 31-i
// of the input.
module bit_reverse32 (
  input  logic [31:0] a,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < 32; i++) begin
      y[i] = a[31-i];
    end
  end

endmodule

// File: rtl/shift_exec_stage_shift_right32.sv
// 32-bit logical right barrel shifter,
// five log2 stages.
module shift_right32 (
  input  logic [31:0] a,
  input  logic [4:0]  amt,
  output logic [31:0] y
);

  always_comb begin
    y = a;
    for (int i = 0; i < 5; i++) begin
      if (amt[i]) begin
        y = y >> (1 << i);
      end
    end
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift execute unit: S1 selects and
// pre-conditions, S2 shifts, fills and registers.
module shift_exec_stage
  import shift_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs,
  input  logic [XLEN-1:0] in_rt,
  input  logic [4:0]      in_shamt,
  input  logic [REGW-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [REGW-1:0] out_rd,
  output logic            out_we
);

  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic            s1_valid_q, s1_valid_d;
  logic            s2_valid_q, s2_valid_d;
  op_dec_t         dec;
  logic            s2_adv;
  logic            accept;
  logic [XLEN-1:0] rt_rev;
  logic [XLEN-1:0] shr;
  logic [XLEN-1:0] r;
  logic [XLEN-1:0] r_rev;
  logic [XLEN-1:0] res;
  logic            unused_rs;

  assign unused_rs = ^in_rs[XLEN-1:5];
  assign dec       = decode_op(in_op);
  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !flush
                   && (!s1_valid_q || s2_adv);
  assign accept    = in_valid && in_ready;

  bit_reverse32 u_rev_in (
    .a (in_rt),
    .y (rt_rev)
  );

  always_comb begin
    s1_d = s1_q;
    if (accept) begin
      s1_d.opnd      = dec.is_left ? rt_rev : in_rt;
      s1_d.amt       = dec.is_var ? in_rs[4:0]
                                  : in_shamt;
      s1_d.is_left   = dec.is_left;
      s1_d.fill_sign = dec.is_arith && in_rt[31];
      s1_d.legal     = dec.legal;
      s1_d.rd        = in_rd;
      s1_d.we        = dec.legal && (in_rd != '0);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  shift_right32 u_shr (
    .a   (s1_q.opnd),
    .amt (s1_q.amt),
    .y   (shr)
  );

  always_comb begin
    r = shr;
    if (s1_q.fill_sign) begin
      r = shr | ~({XLEN{1'b1}} >> s1_q.amt);
    end
  end

  bit_reverse32 u_rev_out (
    .a (r),
    .y (r_rev)
  );

  always_comb begin
    res = '0;
    if (s1_q.legal) begin
      res = s1_q.is_left ? r_rev : r;
    end
  end

  always_comb begin
    s2_d = s2_q;
    if (s2_adv && s1_valid_q) begin
      s2_d.result = res;
      s2_d.rd     = s1_q.rd;
      s2_d.we     = s1_q.we;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_q.result;
  assign out_rd     = s2_q.rd;
  assign out_we     = s2_q.we;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed and randomized-backpressure bench
// for shift_exec_stage.
module tb_shift_exec_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_shamt;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];

  always #5 clock = ~clock;

  shift_exec_stage dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_shamt   (in_shamt),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .out_we     (out_we)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op    = 3'b000;
    in_rs    = '0;
    in_rt    = '0;
    in_shamt = '0;
    in_rd    = '0;
  endtask

  task automatic drive(
    input logic [2:0]  op,
    input logic [31:0] rs,
    input logic [31:0] rt,
    input logic [4:0]  sh,
    input logic [4:0]  rd
  );
    in_valid = 1'b1;
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_shamt = sh;
    in_rd    = rd;
  endtask

  function automatic exp_t ref_m(
    input logic [2:0]  op,
    input logic [31:0] rs,
    input logic [31:0] rt,
    input logic [4:0]  sh,
    input logic [4:0]  rd
  );
    exp_t        e;
    logic [4:0]  a;
    logic [31:0] r;
    logic        legal;
    a = op[2] ? rs[4:0] : sh;
    legal = (op[1:0] != 2'b11);
    case (op)
      3'b000, 3'b100: r = rt << a;
      3'b001, 3'b101: r = rt >> a;
      3'b010, 3'b110: r = $signed(rt) >>> a;
      default:        r = '0;
    endcase
    e.res = r;
    e.rd  = rd;
    e.we  = legal && (rd != 5'd0);
    return e;
  endfunction

  task automatic run1(
    input string       tag,
    input logic [2:0]  op,
    input logic [31:0] rs,
    input logic [31:0] rt,
    input logic [4:0]  sh,
    input logic [4:0]  rd,
    input logic [31:0] exp,
    input logic        exp_we
  );
    out_ready = 1'b1;
    drive(op, rs, rt, sh, rd);
    tick();
    idle();
    chk({tag, "_v0"}, out_valid, 0);
    tick();
    chk({tag, "_v1"}, out_valid, 1);
    chk({tag, "_res"}, out_result, exp);
    chk({tag, "_we"}, out_we, exp_we);
    tick();
  endtask

  initial begin
    int   issued;
    int   got;
    exp_t e;

    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_we", out_we, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // back-to-back, consecutive results
    drive(3'b000, 0, 32'h1, 5'd31, 5'd1);
    tick();
    chk("b2b_v0", out_valid, 0);
    drive(3'b010, 0, 32'h8000_0000, 5'd4, 5'd2);
    tick();
    chk("b2b_sll_v", out_valid, 1);
    chk("b2b_sll", out_result, 32'h8000_0000);
    chk("b2b_sll_rd", out_rd, 1);
    chk("b2b_sll_we", out_we, 1);
    drive(3'b001, 0, 32'h8000_0000, 5'd4, 5'd3);
    tick();
    chk("b2b_sra_v", out_valid, 1);
    chk("b2b_sra", out_result, 32'hF800_0000);
    chk("b2b_sra_rd", out_rd, 2);
    idle();
    tick();
    chk("b2b_srl_v", out_valid, 1);
    chk("b2b_srl", out_result, 32'h0800_0000);
    chk("b2b_srl_rd", out_rd, 3);
    tick();
    chk("b2b_empty", out_valid, 0);

    run1("srav3", 3'b110, 32'hFFFF_FFE3,
         32'hFFFF_FF00, 5'd0, 5'd7,
         32'hFFFF_FFE0, 1'b1);
    run1("srav0", 3'b110, 32'h0000_0020,
         32'h8000_0001, 5'd9, 5'd8,
         32'h8000_0001, 1'b1);
    run1("sra0", 3'b010, 0, 32'h8000_0001,
         5'd0, 5'd8, 32'h8000_0001, 1'b1);
    run1("sra31", 3'b010, 0, 32'h8000_0000,
         5'd31, 5'd9, 32'hFFFF_FFFF, 1'b1);
    run1("sllv4", 3'b100, 32'h4, 32'hF,
         5'd0, 5'd10, 32'hF0, 1'b1);
    run1("srlv1", 3'b101, 32'h21, 32'h8000_0000,
         5'd0, 5'd11, 32'h4000_0000, 1'b1);
    run1("ill111", 3'b111, 32'h1, 32'hFFFF_FFFF,
         5'd3, 5'd5, 32'h0, 1'b0);
    run1("ill011", 3'b011, 32'h1, 32'hFFFF_FFFF,
         5'd3, 5'd5, 32'h0, 1'b0);
    run1("sll_rd0", 3'b000, 0, 32'h3,
         5'd1, 5'd0, 32'h6, 1'b0);

    // backpressure with three ops
    out_ready = 1'b0;
    drive(3'b000, 0, 32'h1, 5'd4, 5'd1);
    tick();
    drive(3'b001, 0, 32'hF0, 5'd4, 5'd2);
    #1;
    chk("bp_rdy2", in_ready, 1);
    tick();
    drive(3'b010, 0, 32'h8000_0000, 5'd1, 5'd3);
    #1;
    chk("bp_rdy3", in_ready, 0);
    chk("bp_res_a", out_result, 32'h10);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold_v", out_valid, 1);
      chk("bp_hold_res", out_result, 32'h10);
      chk("bp_hold_rd", out_rd, 1);
      chk("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", in_ready, 1);
    tick();
    idle();
    chk("bp_b", out_result, 32'h0F);
    chk("bp_b_rd", out_rd, 2);
    tick();
    chk("bp_c", out_result, 32'hC000_0000);
    chk("bp_c_rd", out_rd, 3);
    tick();
    chk("bp_empty", out_valid, 0);

    // random issue and random out_ready
    issued = 0;
    got    = 0;
    for (int cyc = 0; cyc < 600 && got < 24; cyc++) begin
      if (issued < 24 && $urandom_range(0, 3) != 0)
        drive(3'($urandom_range(0, 7)), $urandom,
              $urandom, 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)));
      else
        idle();
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) begin
        q.push_back(ref_m(in_op, in_rs, in_rt,
                          in_shamt, in_rd));
        issued++;
      end
      if (out_valid && out_ready) begin
        got++;
        if (q.size() == 0) begin
          chk("rnd_extra", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rnd_res", out_result, e.res);
          chk("rnd_rd", out_rd, 32'(e.rd));
          chk("rnd_we", out_we, 32'(e.we));
        end
      end
      tick();
    end
    chk("rnd_count", got, 24);
    chk("rnd_left", q.size(), 0);
    idle();
    out_ready = 1'b1;
    tick();
    tick();
    tick();

    // flush with both stages full
    out_ready = 1'b0;
    drive(3'b000, 0, 32'h1, 5'd2, 5'd4);
    tick();
    drive(3'b000, 0, 32'h1, 5'd3, 5'd5);
    tick();
    drive(3'b000, 0, 32'h7, 5'd0, 5'd6);
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("fl_rdy", in_ready, 0);
    chk("fl_v_held", out_valid, 1);
    tick();
    flush = 1'b0;
    idle();
    chk("fl_v0", out_valid, 0);
    drive(3'b001, 0, 32'h100, 5'd8, 5'd6);
    #1;
    chk("fl_rdy_after", in_ready, 1);
    tick();
    idle();
    chk("fl_lat1", out_valid, 0);
    tick();
    chk("fl_lat2", out_valid, 1);
    chk("fl_res", out_result, 32'h1);
    chk("fl_rd", out_rd, 6);
    tick();
    chk("fl_nostale", out_valid, 0);

    // reset with two ops in flight
    drive(3'b000, 0, 32'h5, 5'd1, 5'd7);
    tick();
    drive(3'b001, 0, 32'h80, 5'd1, 5'd8);
    tick();
    idle();
    reset = 1'b1;
    tick();
    chk("mr_valid", out_valid, 0);
    chk("mr_result", out_result, 0);
    chk("mr_rd", out_rd, 0);
    chk("mr_we", out_we, 0);
    reset = 1'b0;
    #1;
    chk("mr_rdy", in_ready, 1);
    tick();
    chk("mr_stale1", out_valid, 0);
    tick();
    chk("mr_stale2", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
